// File: rtl/jtag_debug_cmd_sync.sv
// System-clock side of the debug JTAG link: synchronises update-DR/IR events, buffers DR
// updates in a command FIFO and decodes per-IR action strobes. Optional macro: JDBG_CMD_OVF_FLAG_EN.
module jtag_debug_cmd_sync #(
  parameter int DATA_W      = 38,
  parameter int IR_W        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        sr,
  input  logic [IR_W-1:0]          ir_in,
  input  logic                     vs_udr,
  input  logic                     vs_uir,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [DATA_W-1:0]        cmd_data,
  output logic [IR_W-1:0]          cmd_ir,
  output logic [2**IR_W-1:0]       take_action,
  output logic [2**IR_W-1:0]       take_no_action,
  output logic                     ir_update,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int AW      = $clog2(DEPTH);
  localparam int NSTROBE = 2**IR_W;
  localparam int EW      = IR_W + DATA_W;

  logic [SYNC_STAGES-1:0] udrSync_q, uirSync_q, syncFill_q;
  logic                   udrDly_q, uirDly_q;
  logic                   udrArmed_q, uirArmed_q;
  logic                   pushPend_q, irUpd_q;
  logic                   udrLevel, uirLevel, syncValid;

  assign udrLevel  = udrSync_q[SYNC_STAGES-1];
  assign uirLevel  = uirSync_q[SYNC_STAGES-1];
  // The reset zeros in the chains are not real samples; arming waits until they are flushed.
  assign syncValid = syncFill_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      udrSync_q  <= '0;
      uirSync_q  <= '0;
      syncFill_q <= '0;
      udrDly_q   <= 1'b0;
      uirDly_q   <= 1'b0;
      udrArmed_q <= 1'b0;
      uirArmed_q <= 1'b0;
      pushPend_q <= 1'b0;
      irUpd_q    <= 1'b0;
    end else begin
      udrSync_q  <= {udrSync_q[SYNC_STAGES-2:0], vs_udr};
      uirSync_q  <= {uirSync_q[SYNC_STAGES-2:0], vs_uir};
      syncFill_q <= {syncFill_q[SYNC_STAGES-2:0], 1'b1};
      udrDly_q   <= udrLevel;
      uirDly_q   <= uirLevel;
      if (syncValid && !udrLevel) udrArmed_q <= 1'b1;
      if (syncValid && !uirLevel) uirArmed_q <= 1'b1;
      pushPend_q <= udrArmed_q && udrLevel && !udrDly_q;
      irUpd_q    <= uirArmed_q && uirLevel && !uirDly_q;
    end
  end

  assign ir_update = irUpd_q;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW:0]   wrPtr_q, rdPtr_q;
  logic          full, accept, doPush;

  assign fifo_level = wrPtr_q - rdPtr_q;
  assign full       = (fifo_level == (AW+1)'(DEPTH));
  assign cmd_valid  = (fifo_level != '0);
  assign accept     = cmd_valid && cmd_ready;
  // A full FIFO still takes the push when the head leaves in the same cycle.
  assign doPush     = pushPend_q && (!full || accept);
  assign {cmd_ir, cmd_data} = mem_q[rdPtr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q[AW-1:0]] <= {ir_in, sr};
        wrPtr_q                <= wrPtr_q + 1'b1;
      end
      if (accept) rdPtr_q <= rdPtr_q + 1'b1;
    end
  end

  always_comb begin
    take_action    = '0;
    take_no_action = '0;
    for (int i = 0; i < NSTROBE; i++) begin
      if (accept && (cmd_ir == IR_W'(i))) begin
        take_action[i]    = cmd_data[DATA_W-1];
        take_no_action[i] = !cmd_data[DATA_W-1];
      end
    end
  end

`ifdef JDBG_CMD_OVF_FLAG_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (pushPend_q && full && !accept) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf = ovf_q;
`else
  logic unusedOvfClr;

  assign unusedOvfClr = ovf_clr;
  assign ovf          = 1'b0;
`endif

endmodule
